// File: rtl/dual_shared_divider_if.sv
// Operand/result handshake bundle for dual_shared_divider.
// The producer/consumer side uses the master modport; the divider uses slave.
interface dual_shared_divider_if #(
  parameter int DVD_W = 23,
  parameter int DVS_W = 11,
  parameter int QUO_W = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DVD_W-1:0]  dvd0;
  logic signed [DVD_W-1:0]  dvd1;
  logic        [DVS_W-1:0]  dvs;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [QUO_W-1:0]  quo0;
  logic signed [QUO_W-1:0]  quo1;
  logic signed [QUO_W-1:0]  rem0;
  logic signed [QUO_W-1:0]  rem1;
  logic                     ovf0;
  logic                     ovf1;
  logic                     dz;

  modport master (
    output in_valid, dvd0, dvd1, dvs, out_ready,
    input  in_ready, out_valid, quo0, quo1, rem0, rem1, ovf0, ovf1, dz
  );

  modport slave (
    input  in_valid, dvd0, dvd1, dvs, out_ready,
    output in_ready, out_valid, quo0, quo1, rem0, rem1, ovf0, ovf1, dz
  );
endinterface

// File: rtl/dual_shared_divider.sv
// Two-lane iterative restoring divider: two signed dividends over one shared unsigned divisor.
// Define DUAL_DIV_REM_EN to produce signed remainders; otherwise rem0/rem1 are tied to 0.
module dual_shared_divider #(
  parameter int DVD_W = 23,
  parameter int DVS_W = 11,
  parameter int QUO_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_shared_divider_if.slave bus
);

  localparam int CNT_W = $clog2(QUO_W);
  localparam logic signed [QUO_W-1:0] QMAX = {1'b0, {(QUO_W-1){1'b1}}};
  localparam logic signed [QUO_W-1:0] QMIN = {1'b1, {(QUO_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic                    ovf;
    logic signed [QUO_W-1:0] q;
  } quo_res_t;

  function automatic logic [DVD_W-1:0] abs_mag(input logic signed [DVD_W-1:0] v);
    logic [DVD_W-1:0] m;
    m = v[DVD_W-1] ? -v : v;
    return m;
  endfunction

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor if it fits, and shift the quotient bit in from the right.
  function automatic logic [DVS_W+QUO_W:0] div_step(input logic [DVS_W:0]   pr,
                                                    input logic [QUO_W-1:0] sh,
                                                    input logic [DVS_W-1:0] d);
    logic [DVS_W:0] t;
    logic           qb;
    t  = {pr[DVS_W-1:0], sh[QUO_W-1]};
    qb = (t >= {1'b0, d});
    if (qb) t = t - {1'b0, d};
    return {t, sh[QUO_W-2:0], qb};
  endfunction

  // Sign application and saturation of a quotient magnitude.
  function automatic quo_res_t fix_quo(input logic neg, input logic hi, input logic zdiv,
                                       input logic [QUO_W-1:0] qm);
    quo_res_t res;
    res.ovf = 1'b0;
    res.q   = '0;
    if (zdiv) begin
      res.q = neg ? QMIN : QMAX;
    end else if (!neg) begin
      if (hi || qm[QUO_W-1]) begin
        res.ovf = 1'b1;
        res.q   = QMAX;
      end else begin
        res.q = qm;
      end
    end else begin
      if (hi || (qm[QUO_W-1] && |qm[QUO_W-2:0])) begin
        res.ovf = 1'b1;
        res.q   = QMIN;
      end else begin
        res.q = -qm;
      end
    end
    return res;
  endfunction

`ifdef DUAL_DIV_REM_EN
  function automatic logic signed [QUO_W-1:0] fix_rem(input logic neg, input logic zero,
                                                      input logic [DVS_W:0] rm);
    logic [QUO_W-1:0] mr;
    mr = QUO_W'(rm);
    if (zero) return '0;
    return neg ? -mr : mr;
  endfunction
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [DVD_W-1:0] mag0, mag1;

  logic [DVS_W-1:0] dvs_p0;
  logic             sgn0_p0, sgn1_p0;
  logic             hi0_p0, hi1_p0;
  logic [DVS_W:0]   pr0_p1, pr1_p1;
  logic [QUO_W-1:0] sh0_p1, sh1_p1;

  logic signed [QUO_W-1:0] quo0_p2, quo1_p2;
  logic                    ovf0_p2, ovf1_p2, dz_p2;
  quo_res_t                res0, res1;
  logic                    zdiv;

  assign accept = bus.in_valid && (state == IDLE);
  assign mag0   = abs_mag(bus.dvd0);
  assign mag1   = abs_mag(bus.dvd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= '0;
      else if (state == CALC)  cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)                          state_nxt = CALC;
      CALC: if (cnt == CNT_W'(QUO_W-1))                state_nxt = FIX;
      FIX:                                             state_nxt = DONE;
      DONE: if (bus.out_ready)                         state_nxt = IDLE;
      default:                                         state_nxt = IDLE;
    endcase
  end

  // Stage p0/p1: operand capture, then QUO_W shared-divisor iterations.
  // The dividend's top bits seed the remainder; if they already reach the divisor
  // the quotient magnitude needs more than QUO_W bits and the lane is flagged hi.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs_p0  <= bus.dvs;
      sgn0_p0 <= bus.dvd0[DVD_W-1];
      sgn1_p0 <= bus.dvd1[DVD_W-1];
      hi0_p0  <= (mag0[DVD_W-1:QUO_W] >= bus.dvs);
      hi1_p0  <= (mag1[DVD_W-1:QUO_W] >= bus.dvs);
      pr0_p1  <= {1'b0, mag0[DVD_W-1:QUO_W]};
      pr1_p1  <= {1'b0, mag1[DVD_W-1:QUO_W]};
      sh0_p1  <= mag0[QUO_W-1:0];
      sh1_p1  <= mag1[QUO_W-1:0];
    end else if (state == CALC) begin
      {pr0_p1, sh0_p1} <= div_step(pr0_p1, sh0_p1, dvs_p0);
      {pr1_p1, sh1_p1} <= div_step(pr1_p1, sh1_p1, dvs_p0);
    end
  end

  assign zdiv = (dvs_p0 == '0);
  assign res0 = fix_quo(sgn0_p0, hi0_p0, zdiv, sh0_p1);
  assign res1 = fix_quo(sgn1_p0, hi1_p0, zdiv, sh1_p1);

  // Stage p2: signed, saturated results held until the next FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo0_p2 <= '0;
      quo1_p2 <= '0;
      ovf0_p2 <= 1'b0;
      ovf1_p2 <= 1'b0;
      dz_p2   <= 1'b0;
    end else if (state == FIX) begin
      quo0_p2 <= res0.q;
      quo1_p2 <= res1.q;
      ovf0_p2 <= res0.ovf;
      ovf1_p2 <= res1.ovf;
      dz_p2   <= zdiv;
    end
  end

`ifdef DUAL_DIV_REM_EN
  logic signed [QUO_W-1:0] rem0_p2, rem1_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem0_p2 <= '0;
      rem1_p2 <= '0;
    end else if (state == FIX) begin
      rem0_p2 <= fix_rem(sgn0_p0, zdiv | res0.ovf, pr0_p1);
      rem1_p2 <= fix_rem(sgn1_p0, zdiv | res1.ovf, pr1_p1);
    end
  end

  assign bus.rem0 = rem0_p2;
  assign bus.rem1 = rem1_p2;
`else
  assign bus.rem0 = '0;
  assign bus.rem1 = '0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quo0      = quo0_p2;
  assign bus.quo1      = quo1_p2;
  assign bus.ovf0      = ovf0_p2;
  assign bus.ovf1      = ovf1_p2;
  assign bus.dz        = dz_p2;

endmodule

// File: tb/tb_dual_shared_divider.sv
// Table-driven and scoreboard bench for dual_shared_divider (default 23/11/12 widths).
module tb_dual_shared_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_shared_divider_if bus();
  dual_shared_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef DUAL_DIV_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  typedef struct packed {
    logic signed [11:0] q0, r0, q1, r1;
    logic               o0, o1, dz;
  } exp_t;

  typedef struct {
    logic signed [22:0] a, b;
    logic [10:0]        d;
    exp_t               e;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[10];

  function automatic exp_t mk(input int q0, r0, o0, q1, r1, o1, dz);
    exp_t e;
    e.q0 = 12'(q0); e.r0 = 12'(r0); e.o0 = o0[0];
    e.q1 = 12'(q1); e.r1 = 12'(r1); e.o1 = o1[0];
    e.dz = dz[0];
    return e;
  endfunction

  function automatic void lane_model(input int a, input int d, output int q, output int r,
                                     output int o);
    o = 0;
    if (d == 0) begin
      q = (a >= 0) ? 2047 : -2048;
      r = 0;
    end else begin
      q = a / d;
      r = a - q * d;
      if (q > 2047)       begin q = 2047;  r = 0; o = 1; end
      else if (q < -2048) begin q = -2048; r = 0; o = 1; end
    end
  endfunction

  function automatic exp_t model(input logic signed [22:0] a, b, input logic [10:0] d);
    int q0, r0, o0, q1, r1, o1;
    lane_model(int'(a), int'(d), q0, r0, o0);
    lane_model(int'(b), int'(d), q1, r1, o1);
    return mk(q0, r0, o0, q1, r1, o1, (d == 0) ? 1 : 0);
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: result with no pending expectation (t=%0t)", $time);
    end else begin
      e = sb.pop_front();
      chk("quo0", bus.quo0, e.q0);
      chk("rem0", bus.rem0, REM_EN ? e.r0 : 12'sd0);
      chk("ovf0", {31'b0, bus.ovf0}, {31'b0, e.o0});
      chk("quo1", bus.quo1, e.q1);
      chk("rem1", bus.rem1, REM_EN ? e.r1 : 12'sd0);
      chk("ovf1", {31'b0, bus.ovf1}, {31'b0, e.o1});
      chk("dz",   {31'b0, bus.dz},   {31'b0, e.dz});
    end
  endtask

  task automatic start_op(input logic signed [22:0] a, b, input logic [10:0] d, input exp_t e);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, bus.in_ready}, 1);
    bus.in_valid = 1'b1;
    bus.dvd0 = a;
    bus.dvd1 = b;
    bus.dvs  = d;
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    chk("busy_after_accept", {31'b0, bus.in_ready}, 0);
  endtask

  task automatic wait_done();
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 13);
    cmp_out();
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", {31'b0, bus.in_ready}, 1);
    chk("out_valid_after_release", {31'b0, bus.out_valid}, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic signed [22:0] ra, rb;
    logic [10:0]        rd;

    tbl[0] = '{a: 23'sd1000,     b: -23'sd1000,    d: 11'd7,    e: mk(142, 6, 0, -142, -6, 0, 0)};
    tbl[1] = '{a: -23'sd4192256, b: 23'sd4192256,  d: 11'd2047, e: mk(-2048, 0, 0, 2047, 0, 1, 0)};
    tbl[2] = '{a: 23'sd0,        b: 23'sd4194303,  d: 11'd1,    e: mk(0, 0, 0, 2047, 0, 1, 0)};
    tbl[3] = '{a: 23'sd5,        b: -23'sd5,       d: 11'd0,    e: mk(2047, 0, 0, -2048, 0, 0, 1)};
    tbl[4] = '{a: 23'sd1851000,  b: -23'sd3072000, d: 11'd1500, e: mk(1234, 0, 0, -2048, 0, 0, 0)};
    tbl[5] = '{a: -23'sd4194304, b: 23'sd4194303,  d: 11'd2047, e: mk(-2048, 0, 1, 2047, 0, 1, 0)};
    tbl[6] = '{a: -23'sd7,       b: 23'sd6,        d: 11'd2,    e: mk(-3, -1, 0, 3, 0, 0, 0)};
    tbl[7] = '{a: 23'sd6,        b: -23'sd2047,    d: 11'd7,    e: mk(0, 6, 0, -292, -3, 0, 0)};
    tbl[8] = '{a: 23'sd4192255,  b: -23'sd4192255, d: 11'd2047, e: mk(2047, 2046, 0, -2047, -2046, 0, 0)};
    tbl[9] = '{a: -23'sd4194302, b: 23'sd0,        d: 11'd2047, e: mk(-2048, -2046, 0, 0, 0, 0, 0)};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dvd0 = '0;
    bus.dvd1 = '0;
    bus.dvs  = '0;

    #12;
    chk("rst_in_ready",  {31'b0, bus.in_ready},  1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_quo0", bus.quo0, 0);
    chk("rst_quo1", bus.quo1, 0);
    chk("rst_ovf",  {30'b0, bus.ovf1, bus.ovf0}, 0);
    chk("rst_dz",   {31'b0, bus.dz}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e);
      wait_done();
      release_out();
    end

    for (int i = 0; i < 8; i++) begin
      ra = 23'($urandom);
      rb = 23'($urandom);
      rd = (i < 3) ? 11'($urandom_range(1, 15)) : 11'($urandom);
      start_op(ra, rb, rd, model(ra, rb, rd));
      wait_done();
      release_out();
    end

    // Backpressure: results must hold and new operands must be ignored.
    start_op(tbl[0].a, tbl[0].b, tbl[0].d, tbl[0].e);
    wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.dvd0 = 23'($urandom);
      bus.dvd1 = 23'($urandom);
      bus.dvs  = 11'($urandom);
      @(posedge clk);
      #1;
      chk("bp_in_ready",  {31'b0, bus.in_ready},  0);
      chk("bp_out_valid", {31'b0, bus.out_valid}, 1);
      chk("bp_quo0", bus.quo0, 142);
      chk("bp_quo1", bus.quo1, -142);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    release_out();
    chk("bp_held_quo0", bus.quo0, 142);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_spurious_valid", {31'b0, bus.out_valid}, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset during the 6th CALC cycle aborts the operation.
    start_op(tbl[4].a, tbl[4].b, tbl[4].d, tbl[4].e);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    chk("abort_quo0", bus.quo0, 0);
    chk("abort_quo1", bus.quo1, 0);
    chk("abort_flags", {29'b0, bus.ovf0, bus.ovf1, bus.dz}, 0);
    chk("abort_rem", {bus.rem0, bus.rem1}, 0);
    chk("abort_out_valid", {31'b0, bus.out_valid}, 0);
    chk("abort_in_ready",  {31'b0, bus.in_ready},  1);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(tbl[0].a, tbl[0].b, tbl[0].d, tbl[0].e);
    wait_done();
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
